// File: rtl/tail_light_pkg.sv
// Shared state codes and constants for the tail-light sequencer
// and the LED output decoder that consumes its outputs.
package tail_light_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0000,
      ST_HAZARD  = 4'b0001,
      ST_TURN    = 4'b0010,
      ST_BRAKE   = 4'b0011,
      ST_RIGHT   = 4'b0100,
      ST_LEFT    = 4'b0101,
      ST_B_RIGHT = 4'b0110,
      ST_B_LEFT  = 4'b0111
   } state_e;

   localparam logic [2:0] SWEEP_MAX = 3'd5;
   localparam logic [2:0] HAZ_ON    = 3'b111;
   localparam logic [2:0] HAZ_OFF   = 3'b000;

   typedef struct packed {
      logic left;
      logic right;
      logic brake;
      logic hazard;
   } sw_t;

   function automatic logic is_sweep(input state_e s);
      return (s == ST_LEFT) || (s == ST_RIGHT) ||
             (s == ST_B_LEFT) || (s == ST_B_RIGHT);
   endfunction

   // Priority: hazard (or both turns) > left > right > brake > idle.
   function automatic state_e next_state(input sw_t s);
      logic haz_c;
      logic left_c;
      logic right_c;
      logic brake_c;
      state_e ns;
      haz_c   = s.hazard | (s.left & s.right);
      left_c  = s.left & ~haz_c;
      right_c = s.right & ~haz_c & ~s.left;
      brake_c = s.brake & ~haz_c & ~s.left & ~s.right;
      ns = ST_IDLE;
      unique case (1'b1)
         haz_c:   ns = ST_HAZARD;
         left_c:  ns = s.brake ? ST_B_LEFT : ST_LEFT;
         right_c: ns = s.brake ? ST_B_RIGHT : ST_RIGHT;
         brake_c: ns = ST_BRAKE;
         default: ns = ST_IDLE;
      endcase
      return ns;
   endfunction

endpackage

// File: rtl/tail_light_sequencer_tick_gen.sv
// Free-running divider producing a registered one-cycle strobe
// every TICK_DIV clocks; reusable across board projects.
module tick_gen #(
   parameter int TICK_DIV = 12_500_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic         tick_q;
   logic         tick_d;

   always_comb begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      tick_d  = (count_d == LAST);
   end

   // tick_q is high exactly while count_q sits at LAST
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/tail_light_sequencer.sv
// Tail-light sequencer: switch synchronisers, priority FSM and
// sweep/hazard animation counters feeding the LED decoder.
module tail_light_sequencer
   import tail_light_pkg::*;
#(
   parameter int TICK_DIV = 12_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       left_sw,
   input  logic       right_sw,
   input  logic       brake_sw,
   input  logic       hazard_sw,
   output logic [3:0] CurrentState,
   output logic [2:0] counter,
   output logic [2:0] hazard,
   output logic       tick
);

   sw_t        sw_raw;
   sw_t        sync1_q;
   sw_t        sync2_q;
   state_e     state_q;
   state_e     state_d;
   logic [2:0] counter_q;
   logic [2:0] counter_d;
   logic [2:0] hazard_q;
   logic [2:0] hazard_d;
   logic       tick_w;

   tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .tick(tick_w)
   );

   assign sw_raw = {left_sw, right_sw, brake_sw, hazard_sw};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sw_raw;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         counter_q <= '0;
         hazard_q  <= HAZ_OFF;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         hazard_q  <= hazard_d;
      end
   end

   always_comb begin
      state_d = next_state(sync2_q);
   end

   // A state change restarts the animation and beats a coincident tick
   always_comb begin
      counter_d = counter_q;
      hazard_d  = hazard_q;
      if (state_d != state_q) begin
         counter_d = '0;
         hazard_d  = (state_d == ST_HAZARD) ? HAZ_ON : HAZ_OFF;
      end else if (tick_w) begin
         if (is_sweep(state_q)) begin
            counter_d = (counter_q == SWEEP_MAX) ? '0
                      : counter_q + 3'd1;
         end
         if (state_q == ST_HAZARD) begin
            hazard_d = ~hazard_q;
         end
      end
   end

   assign CurrentState = state_q;
   assign counter      = counter_q;
   assign hazard       = hazard_q;
   assign tick         = tick_w;

endmodule
